uart_led: RTL and testbench

UART receiver/transmitter for the board top level. It receives 8N1 serial bytes on `uart_rx` and shows the low six bits of the last good byte on the active-low LEDs. On each press of `btn1` it transmits a fixed ASCII message on `uart_tx`. Bit timing is set by a clocks-per-bit parameter; there is no baud generator and no fractional divider.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_engine.sv | 63 ++++++
 rtl/uart_led.sv | 142 ++++++++++++++
 tb/tb_uart_led.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, frame sizes and the button message shared by uart_led and its TX engine.
package uart_pkg;
    localparam int BITS_PER_BYTE = 8;
    localparam int MSG_LEN = 16;
    localparam int IDX_W = $clog2(MSG_LEN);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam logic [7:0] MSG [MSG_LEN] = '{
        "T", "e", "s", "t", " ", "t", "h", "e",
        " ", "U", "A", "R", "T", "!", 8'h0d, 8'h0a
    };
endpackage

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1 serializer; a start strobe is accepted while busy is low, including the
// last clock of a stop bit, so consecutive frames run back-to-back.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    localparam logic [7:0] BIT_LAST = 8'(DELAY_FRAMES - 1);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    tx_state_t  state_q;
    logic [7:0] cnt_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic       tx_q;
    logic       bit_end;

    assign bit_end = cnt_q == BIT_LAST;
    assign busy = state_q != TX_IDLE && !(state_q == TX_STOP && bit_end);
    assign tx = tx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            cnt_q <= (bit_end || state_q == TX_IDLE) ? 8'd0 : cnt_q + 8'd1;
            if (start && !busy) begin
                state_q <= TX_START;
                shift_q <= data;
                tx_q    <= 1'b0;
            end else if (bit_end) begin
                case (state_q)
                    TX_START: begin
                        state_q <= TX_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                    TX_DATA: begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= shift_q >> 1;
                        state_q <= bit_q == LAST_BIT ? TX_STOP : TX_DATA;
                        tx_q    <= bit_q == LAST_BIT ? 1'b1 : shift_q[1];
                    end
                    default: begin
                        state_q <= TX_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_led.sv
// uart_led: 8N1 receiver driving active-low LEDs, plus a button-triggered message transmitter.
// Define UART_ECHO_EN to also retransmit every valid received byte.
module uart_led
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [5:0] led
);
    localparam logic [7:0] BIT_LAST  = 8'(DELAY_FRAMES - 1);
    localparam logic [7:0] HALF_LAST = 8'(DELAY_FRAMES / 2 - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    logic [1:0]       rx_sync_q;
    logic [1:0]       btn_sync_q;
    logic             btn_prev_q;
    rx_state_t        rx_state_q;
    logic [7:0]       rx_cnt_q;
    logic [7:0]       rx_data_q;
    logic [2:0]       rx_bit_q;
    logic [5:0]       led_q;
    logic             send_q, send_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_start, tx_busy;
    logic [7:0]       tx_byte;
    logic             rx, press, rx_good;

    assign rx = rx_sync_q[1];
    assign press = btn_prev_q && !btn_sync_q[1];
    assign rx_good = rx_state_q == RX_STOP && rx_cnt_q == BIT_LAST && rx;
    assign led = led_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            btn_sync_q <= 2'b11;
            btn_prev_q <= 1'b1;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            btn_sync_q <= {btn_sync_q[0], btn1};
            btn_prev_q <= btn_sync_q[1];
        end
    end

    // START samples at mid-bit; every later sample is a full bit period after the previous one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_bit_q   <= '0;
            led_q      <= '1;
        end else begin
            rx_cnt_q <= rx_cnt_q + 8'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx) rx_state_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q  <= '0;
                    rx_data_q <= {rx, rx_data_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 3'd1;
                    if (rx_bit_q == LAST_BIT) rx_state_q <= RX_STOP;
                end
                default: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                    if (rx_good) led_q <= ~rx_data_q[5:0];
                end
            endcase
        end
    end

`ifdef UART_ECHO_EN
    logic [7:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`endif

    // idx_q is always 0 while no message is in flight, so a press simply starts at MSG[idx_q]
    always_comb begin
        send_d   = send_q;
        idx_d    = idx_q;
        tx_start = 1'b0;
        tx_byte  = MSG[idx_q];
`ifdef UART_ECHO_EN
        pend_d     = rx_good ? rx_data_q : pend_q;
        pend_vld_d = rx_good || pend_vld_q;
`endif
        if (!tx_busy && (send_q || press)) begin
            tx_start = 1'b1;
            idx_d    = idx_q + 1'b1;
            send_d   = idx_q != IDX_W'(MSG_LEN - 1);
        end
`ifdef UART_ECHO_EN
        else if (!tx_busy && pend_vld_q) begin
            tx_start   = 1'b1;
            tx_byte    = pend_q;
            pend_vld_d = rx_good;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            send_q <= send_d;
            idx_q  <= idx_d;
        end
    end

    uart_tx_engine #(.DELAY_FRAMES(DELAY_FRAMES)) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(tx_start),
        .data (tx_byte),
        .busy (tx_busy),
        .tx   (uart_tx)
    );
endmodule

// File: tb/tb_uart_led.sv
// tb_uart_led: randomized RX frames and button messages checked against a frame-level model.
module tb_uart_led;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn1 = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [5:0] led;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [5:0] led_exp = 6'h3f;
    logic [8:0] txq [$];
    string      msg = "Test the UART!\r\n";

    uart_led #(.DELAY_FRAMES(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn1   (btn1),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .led    (led)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial line driver; the LED model is simply "last byte with a high stop bit, inverted".
    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            uart_rx = f[i];
            repeat (D) @(negedge clk);
        end
        uart_rx = stop;
        repeat (5) @(negedge clk);
        check("led_hold", 32'(led), 32'(led_exp));
        repeat (3) @(negedge clk);
        if (stop) led_exp = ~b[5:0];
        check("led_upd", 32'(led), 32'(led_exp));
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Line decoder: {stop_and_start_ok, byte} per frame seen on uart_tx
    always begin
        logic [7:0] b;
        logic       ok;
        @(negedge uart_tx);
        repeat (D / 2) @(negedge clk);
        ok = !uart_tx;
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (D) @(negedge clk);
        ok = ok && uart_tx;
        txq.push_back({ok, b});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        repeat (4) @(negedge clk);
        check("reset_led", 32'(led), 32'h3f);
        check("reset_tx", 32'(uart_tx), 32'h1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_byte(8'h61, 1'b1, 2 * D);
        check("led_a", 32'(led), 32'h1e);
        send_byte(8'h3f, 1'b1, 0);
        check("led_3f", 32'(led), 32'h00);
        send_byte(8'h00, 1'b1, 2 * D);
        check("led_00", 32'(led), 32'h3f);
        send_byte(8'h61, 1'b1, 2 * D);

        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        check("glitch_led", 32'(led), 32'(led_exp));

        send_byte(8'h55, 1'b0, 2 * D);
        check("framing_led", 32'(led), 32'h1e);

        txq.delete();
        fork
            begin
                int n;
                btn1 = 1'b0;
                n = 0;
                while (uart_tx && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("tx_latency", 32'(n), 32'd3);
                repeat (40) @(negedge clk);
                btn1 = 1'b1;
                repeat (450) @(negedge clk);
                btn1 = 1'b0;
                repeat (10) @(negedge clk);
                btn1 = 1'b1;
                for (int k = 0; k < 2500 && txq.size() < 16; k++) @(negedge clk);
                check("tx_count", 32'(txq.size()), 32'd16);
                repeat (40 * D) @(negedge clk);
                check("tx_count_after", 32'(txq.size()), 32'd16);
                for (int i = 0; i < 16 && i < txq.size(); i++)
                    check("tx_frame", 32'(txq[i]), {23'd0, 1'b1, msg[i]});
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    logic stop;
                    stop = $urandom_range(3) != 0;
                    send_byte(8'($urandom), stop, stop ? int'($urandom_range(2 * D)) : 2 * D);
                end
            end
        join

        btn1 = 1'b0;
        repeat (20) @(negedge clk);
        btn1 = 1'b1;
        rb = 8'h61;
        uart_rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = rb[i];
            repeat (D) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_led", 32'(led), 32'h3f);
        check("rst_mid_tx", 32'(uart_tx), 32'h1);
        uart_rx = 1'b1;
        rst_n = 1'b1;
        led_exp = 6'h3f;
        repeat (3 * D) @(negedge clk);
        check("rst_tx_idle", 32'(uart_tx), 32'h1);
        repeat (100) @(negedge clk);
        txq.delete();
        send_byte(8'h61, 1'b1, 2 * D);
        check("post_rst_led", 32'(led), 32'h1e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
